// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared widths and per-beat config for the post-quant pipe
package ppu_pkg;

    localparam int IN_BITS    = 32;
    localparam int OUT_BITS   = 8;
    localparam int SHIFT_BITS = 6;
    localparam int LANES      = 4;

    typedef struct packed {
        logic [SHIFT_BITS-1:0] scaling_factor;
        logic [OUT_BITS-1:0]   zero_point;
        logic                  relu_en;
        logic                  round_en;
    } pq_cfg_t;

endpackage

// File: rtl/pq_lane.sv
// rtl/pq_lane.sv - per-lane round/shift, relu, zero-point add and unsigned clamp
module pq_lane
    import ppu_pkg::*;
(
    input  logic signed [IN_BITS-1:0] x,
    input  pq_cfg_t                   cfg,
    output logic [OUT_BITS-1:0]       q,
    output logic                      sat
);

    localparam int SW = $clog2(IN_BITS + 1);

    logic [SW-1:0]             s;
    logic signed [IN_BITS:0]   bias;
    logic signed [IN_BITS:0]   t;
    logic signed [IN_BITS:0]   r;
    logic signed [IN_BITS:0]   rp;
    logic signed [IN_BITS+1:0] zp_ext;
    logic signed [IN_BITS+1:0] max_v;
    logic signed [IN_BITS+1:0] y;

    // Shifts past the input width all collapse to the sign of t.
    always_comb begin
        s = SW'(cfg.scaling_factor);
        if (int'(cfg.scaling_factor) > IN_BITS) begin
            s = SW'(IN_BITS);
        end
    end

    assign bias   = (cfg.round_en && s != '0) ? ((IN_BITS+1)'(1) << (s - SW'(1))) : '0;
    assign t      = {x[IN_BITS-1], x} + bias;
    assign r      = t >>> s;
    assign rp     = (cfg.relu_en && r[IN_BITS]) ? '0 : r;
    assign zp_ext = {{(IN_BITS+2-OUT_BITS){1'b0}}, cfg.zero_point};
    assign max_v  = {{(IN_BITS+2-OUT_BITS){1'b0}}, {OUT_BITS{1'b1}}};
    assign y      = {rp[IN_BITS], rp} + zp_ext;

    always_comb begin
        q   = y[OUT_BITS-1:0];
        sat = 1'b0;
        if (y[IN_BITS+1]) begin
            q   = '0;
            sat = 1'b1;
        end else if (y > max_v) begin
            q   = '1;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/ppu_post_quant_pipe.sv
// rtl/ppu_post_quant_pipe.sv - two-stage multi-lane post-quant pipe with valid/ready and saturation counter
module ppu_post_quant_pipe #(
    parameter int IN_BITS    = ppu_pkg::IN_BITS,
    parameter int OUT_BITS   = ppu_pkg::OUT_BITS,
    parameter int LANES      = ppu_pkg::LANES,
    parameter int SHIFT_BITS = ppu_pkg::SHIFT_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*IN_BITS-1:0]  in_data,
    input  logic [SHIFT_BITS-1:0]     scaling_factor,
    input  logic [OUT_BITS-1:0]       zero_point,
    input  logic                      relu_en,
    input  logic                      round_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_BITS-1:0] out_data,
    output logic                      sat_any,
    input  logic                      sat_clr,
    output logic [15:0]               sat_cnt
);

    ppu_pkg::pq_cfg_t in_cfg;
    ppu_pkg::pq_cfg_t s1_cfg;

    logic                      s1_valid;
    logic                      s2_valid;
    logic [LANES*IN_BITS-1:0]  s1_data;
    logic [LANES*OUT_BITS-1:0] lane_q;
    logic [LANES-1:0]          lane_sat;
    logic                      s2_load;

    assign in_cfg    = '{scaling_factor: scaling_factor, zero_point: zero_point,
                         relu_en: relu_en, round_en: round_en};
    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;

    // S1 captures the raw beat with its own config so later config changes never leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_cfg   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_cfg  <= in_cfg;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pq_lane u_lane (
            .x   (s1_data[i*IN_BITS +: IN_BITS]),
            .cfg (s1_cfg),
            .q   (lane_q[i*OUT_BITS +: OUT_BITS]),
            .sat (lane_sat[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            sat_any  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= lane_q;
                sat_any  <= |lane_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (out_valid && out_ready && sat_any && sat_cnt != 16'hFFFF) begin
            sat_cnt <= sat_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ppu_post_quant_pipe.sv
// tb/tb_ppu_post_quant_pipe.sv - scoreboard bench for ppu_post_quant_pipe
module tb_ppu_post_quant_pipe;

    localparam int IB = 32;
    localparam int OB = 8;
    localparam int L  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [L*IB-1:0] in_data = '0;
    logic [5:0]      scaling_factor = '0;
    logic [7:0]      zero_point = 8'd128;
    logic            relu_en = 1'b0;
    logic            round_en = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [L*OB-1:0] out_data;
    logic            sat_any;
    logic            sat_clr = 1'b0;
    logic [15:0]     sat_cnt;

    ppu_post_quant_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .scaling_factor(scaling_factor), .zero_point(zero_point),
        .relu_en(relu_en), .round_en(round_en), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sat_any(sat_any),
        .sat_clr(sat_clr), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [L*OB-1:0] data;
        logic            sat;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic bp_on = 1'b0;
    logic seen_full = 1'b0;
    int   bp_hs = 0;
    int   gaps = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bp_on) begin
            if (out_valid && !out_ready && !in_ready) seen_full = 1'b1;
            if (bp_hs > 0 && out_ready && !out_valid && exp_q.size() > 0) gaps++;
            if (out_valid && out_ready) bp_hs++;
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got %0h required none", out_data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 64'(out_data), 64'(e.data));
                check("beat_sat", 64'(sat_any), 64'(e.sat));
            end
        end
    end

    function automatic logic [L*IB-1:0] lane0(input int x);
        logic [L*IB-1:0] d;
        d = '0;
        d[IB-1:0] = x;
        return d;
    endfunction

    function automatic logic [L*OB-1:0] exp0(input int v);
        return {8'd128, 8'd128, 8'd128, 8'(v)};
    endfunction

    // Leaves in_valid high on return so back-to-back calls stream one beat per cycle.
    task automatic send_beat(input logic [L*IB-1:0] d, input int sf, input int relu,
                             input int rnd, input logic [L*OB-1:0] ed, input logic es);
        bit ok;
        exp_t e;
        in_data        = d;
        scaling_factor = 6'(sf);
        relu_en        = relu[0];
        round_en       = rnd[0];
        in_valid       = 1'b1;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            e.data = ed;
            e.sat  = es;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    int dx[9]   = '{1000, 1004, 1004, -300, 200, 127, -50, -5, -5};
    int ds[9]   = '{3, 3, 3, 0, 0, 0, 1, 40, 40};
    int drl[9]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    int drn[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1};
    int dex[9]  = '{253, 253, 254, 0, 255, 255, 128, 127, 128};
    int dsat[9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    initial begin
        logic [L*IB-1:0] bd;
        logic [L*OB-1:0] be;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_sat_any", 64'(sat_any), 64'd0);
        check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++)
            send_beat(lane0(dx[i]), ds[i], drl[i], drn[i], exp0(dex[i]), dsat[i][0]);
        in_valid = 1'b0;
        drain();
        check("sat_cnt_directed", 64'(sat_cnt), 64'd2);

        // Lane i of beat b is (10*i+b)<<b with shift b, so each lane lands on 128+10*i+b.
        out_ready = 1'b0;
        bp_on = 1'b1;
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < L; i++) begin
                        bd[i*IB +: IB] = IB'((10*i + b) << b);
                        be[i*OB +: OB] = OB'(128 + 10*i + b);
                    end
                    send_beat(bd, b, 0, 0, be, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                wait_out_valid();
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        bp_on = 1'b0;
        check("bp_in_ready_fell", 64'(seen_full), 64'd1);
        check("bp_handshakes", 64'(bp_hs), 64'd8);
        check("bp_gaps", 64'(gaps), 64'd0);

        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_cnt_clr", 64'(sat_cnt), 64'd0);
        for (int i = 0; i < 3; i++)
            send_beat(lane0(-300), 0, 0, 0, exp0(0), 1'b1);
        in_valid = 1'b0;
        drain();
        check("sat_cnt_three", 64'(sat_cnt), 64'd3);

        out_ready = 1'b0;
        send_beat(lane0(200), 0, 0, 0, exp0(255), 1'b1);
        in_valid = 1'b0;
        wait_out_valid();
        @(posedge clk);
        #1;
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("sat_cnt_clr_wins", 64'(sat_cnt), 64'd0);
        check("clr_beat_consumed", 64'(exp_q.size()), 64'd0);

        @(negedge clk);
        force dut.sat_cnt = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.sat_cnt;
        check("sat_cnt_preload", 64'(sat_cnt), 64'hFFFD);
        for (int i = 0; i < 4; i++)
            send_beat(lane0(-300), 0, 0, 0, exp0(0), 1'b1);
        in_valid = 1'b0;
        drain();
        check("sat_cnt_sticky", 64'(sat_cnt), 64'hFFFF);

        out_ready = 1'b0;
        send_beat(lane0(1000), 3, 0, 0, exp0(253), 1'b0);
        send_beat(lane0(-300), 0, 0, 0, exp0(0), 1'b1);
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_beat(lane0(1004), 3, 0, 1, exp0(254), 1'b0);
        in_valid = 1'b0;
        check("lat_after_1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_after_2", 64'(out_valid), 64'd1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/ppu_post_quant_pipe.md
# ppu_post_quant_pipe

Multi-lane, pipelined post-quantization stage for the PPU. Takes LANES signed accumulator results per beat and applies the same steps to every lane: optional round-half-up, arithmetic right shift by a per-beat scaling factor, optional ReLU, programmable zero-point offset, and unsigned clamp to OUT_BITS. It sits between the accumulator drain and the output writer, with valid/ready handshakes on both sides and a saturation event counter for calibration debug.

## Interface
- IN_BITS, 32, signed input width per lane
- OUT_BITS, 8, unsigned output width per lane
- LANES, 4, lanes processed per beat
- SHIFT_BITS, 6, scaling_factor width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  LANES*IN_BITS  lane i at [i*IN_BITS +: IN_BITS], signed
- scaling_factor  input  SHIFT_BITS  right-shift amount, sampled with the beat
- zero_point  input  OUT_BITS  unsigned offset, sampled with the beat
- relu_en  input  1  force negative shifted values to 0, sampled with the beat
- round_en  input  1  round-half-up before the shift, sampled with the beat
- out_valid  output  1  output beat valid
- out_ready  input  1  output beat consumed when out_valid && out_ready
- out_data  output  LANES*OUT_BITS  lane i at [i*OUT_BITS +: OUT_BITS], unsigned
- sat_any  output  1  at least one lane of the current output beat was clamped
- sat_clr  input  1  synchronous clear of sat_cnt
- sat_cnt  output  16  count of consumed output beats with sat_any=1

## Operation
- Config travels with its beat. Changing scaling_factor, zero_point, relu_en or round_en between beats never affects beats already in flight.
- Effective shift: s = min(scaling_factor, IN_BITS).
- Stage 1, per lane, computed in IN_BITS+1 bits signed:
  - t = x + (round_en && s>0 ? 2^(s-1) : 0)
  - r = t >>> s
  - Result is floor((x + bias) / 2^s).
- Stage 2, per lane:
  - r' = (relu_en && r<0) ? 0 : r
  - y = r' + zero_point, using a sign-extended adder wide enough that it cannot overflow.
  - out = clamp(y, 0, 2^OUT_BITS-1).
  - Lane saturated = (y<0) || (y>2^OUT_BITS-1).
  - sat_any = OR of all lane saturated flags, registered alongside out_data.
- sat_cnt:
  - Increments by 1 on each output handshake with sat_any=1.
  - Sticks at 0xFFFF.
  - sat_clr clears it to 0. When sat_clr and an increment occur in the same cycle, the clear wins and sat_cnt=0.
- With zero_point=128, relu_en=0, round_en=0 and OUT_BITS=8, the block is bit-exact with the current single-lane uint8 post-quant path.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, sat_any=0, sat_cnt=0, and all internal valids 0. Reset is asynchronous, so any in-flight beats are discarded immediately.
- Pipeline is two register stages (S1, S2). Latency from input handshake to out_valid is 2 cycles. Throughput is 1 beat per cycle while out_ready=1.
- Flow control:
  - S2 loads when !s2_valid || out_ready.
  - S1 advances under the same condition.
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready; no combinational path exists from in_valid to in_ready.
- When out_valid=1 and out_ready=0:
  - out_data and sat_any hold stable.
  - S1 may still fill if it is empty.
  - in_ready drops once both stages are full.
- No beat is dropped, duplicated or reordered. Bubbles collapse.
- out_valid deasserts only after a handshake with no successor beat in S1.

## Structure
- Shared package ppu_pkg holds:
  - Default widths (IN_BITS, OUT_BITS, SHIFT_BITS, LANES).
  - Typedef pq_cfg_t bundling scaling_factor, zero_point, relu_en and round_en. This is the per-beat config carried through S1.
- Sub-module pq_lane holds the per-lane stage-1 and stage-2 arithmetic with enables. It is instantiated LANES times by generate.
- The top level owns the valid/ready control, the config register, the sat_any reduction and sat_cnt.

## Test plan
Unless stated otherwise: IN_BITS=32, OUT_BITS=8, zp=128, relu_en=0, round_en=0.
- Shift and round: x=1000, s=3 -> 253. x=1004, s=3 -> 253 with round_en=0 and 254 with round_en=1. All results have sat_any=0.
- Clamp: x=-300, s=0 -> 0 with sat_any=1. x=200, s=0 -> 255 with sat_any=1. x=127, s=0 -> 255 with sat_any=0.
- ReLU and oversize shift: x=-50, s=1, relu_en=1 -> 128 with sat_any=0. x=-5, s=40 -> 127 with round_en=0 and 128 with round_en=1.
- Backpressure: stream 8 beats with distinct per-lane values and per-beat changing s, holding out_ready=0 for 3 cycles after the first out_valid.
  - Required: in_ready falls once both stages are full.
  - Required: output order and values match the reference model exactly.
  - Required: 1 beat/cycle while out_ready=1.
- Counter:
  - 3 consumed beats with sat_any=1 -> sat_cnt=3.
  - sat_clr in the same cycle as a 4th saturating handshake -> sat_cnt=0.
  - Preloading the counter near 0xFFFF -> it sticks at 0xFFFF.
- Reset mid-stream: assert rst with both stages full -> out_valid=0, out_data=0, sat_cnt=0 immediately. After release, the first new beat appears 2 cycles after its input handshake.
